// File: rtl/crossbar_out_arbiter.sv
// ---------------------------------------------------------------------------
// crossbar_out_arbiter
//
// Purpose
//   Per-output-port scheduler for the crossbar. Each requesting line raises
//   its bit of i_trans_req while it has a packet for this output. The block
//   grants one line at a time (round-robin), holds that grant for one whole
//   packet, and watches the muxed output AXIS stream to find the packet end.
//
// Optional feature
//   CROSSBAR_ARB_TIMEOUT_EN : when defined, a stall counter force-releases a
//   grant that sees no beat for P_TIMEOUT consecutive granted cycles and
//   pulses o_timeout for one cycle. When undefined, o_timeout is tied 0.
//
// Handshake
//   A beat transfers on a rising clock edge where i_tx_tvalid and
//   i_tx_tready are both 1. A last beat is a beat with i_tx_tlast=1.
//   Beats seen while no grant is held are ignored.
//
// Ports
//   i_clk          clock
//   i_rst          asynchronous reset, active low (0 = reset)
//   i_trans_req    [N-1:0] request per line, held until its tlast beat
//   o_trans_grant  [N-1:0] one-hot or zero grant per line
//   i_tx_tvalid    tvalid of muxed output stream
//   i_tx_tlast     tlast of muxed output stream
//   i_tx_tready    tready from downstream sink
//   o_sel          index of granted line (valid while o_busy=1)
//   o_busy         1 while a grant is held
//   o_timeout      1-cycle pulse on forced release
//   o_dbg_state    current FSM state (0 IDLE, 1 GRANT, 2 GAP)
// ---------------------------------------------------------------------------
module crossbar_out_arbiter #(
  parameter int P_CROSSBAR_N = 4,
  parameter int P_SEL_W      = 2,
  parameter int P_TIMEOUT    = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [P_CROSSBAR_N-1:0] i_trans_req,
  output logic [P_CROSSBAR_N-1:0] o_trans_grant,
  input  logic                    i_tx_tvalid,
  input  logic                    i_tx_tlast,
  input  logic                    i_tx_tready,
  output logic [P_SEL_W-1:0]      o_sel,
  output logic                    o_busy,
  output logic                    o_timeout,
  output logic [1:0]              o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [P_SEL_W:0]   LP_N    = (P_SEL_W+1)'(P_CROSSBAR_N);
  localparam logic [P_SEL_W-1:0] LP_LAST = P_SEL_W'(P_CROSSBAR_N - 1);

  // Registers
  state_t                    r_state;
  logic [P_CROSSBAR_N-1:0]   r_grant;
  logic [P_SEL_W-1:0]        r_sel;
  logic [P_SEL_W-1:0]        r_rr_ptr;
  logic                      r_beat_seen;
  logic                      r_timeout;

  // Next-state values
  state_t                    w_state_nxt;
  logic [P_CROSSBAR_N-1:0]   w_grant_nxt;
  logic [P_SEL_W-1:0]        w_sel_nxt;
  logic [P_SEL_W-1:0]        w_rr_nxt;
  logic                      w_beat_seen_nxt;
  logic                      w_timeout_nxt;

  // Stream and arbitration helpers
  logic                      w_beat;
  logic                      w_last_beat;
  logic                      w_req_own;
  logic                      w_withdraw;
  logic                      w_to_hit;
  logic                      w_release;
  logic [2*P_CROSSBAR_N-1:0] w_req_dbl;
  logic [P_CROSSBAR_N-1:0]   w_req_rot;
  logic                      w_pick_found;
  logic [P_SEL_W-1:0]        w_pick_off;
  logic [P_SEL_W:0]          w_pick_sum;
  logic [P_SEL_W-1:0]        w_pick_idx;
  logic [P_CROSSBAR_N-1:0]   w_pick_onehot;

  assign w_beat      = i_tx_tvalid & i_tx_tready;
  assign w_last_beat = w_beat & i_tx_tlast;

  // Requests rotated so that bit 0 is the line the rr pointer points at;
  // the lowest set bit of the rotated vector is the round-robin winner.
  assign w_req_dbl = {i_trans_req, i_trans_req} >> r_rr_ptr;
  assign w_req_rot = w_req_dbl[P_CROSSBAR_N-1:0];

  always_comb begin
    w_pick_found = 1'b0;
    w_pick_off   = '0;
    // Descending scan: the last hit written is the lowest offset.
    for (int j = P_CROSSBAR_N - 1; j >= 0; j--) begin
      if (w_req_rot[j]) begin
        w_pick_found = 1'b1;
        w_pick_off   = P_SEL_W'(j);
      end
    end
  end

  // Offset back to an absolute line index, wrapping modulo N (N need not
  // be a power of two).
  assign w_pick_sum    = {1'b0, r_rr_ptr} + {1'b0, w_pick_off};
  assign w_pick_idx    = (w_pick_sum >= LP_N) ? P_SEL_W'(w_pick_sum - LP_N)
                                              : w_pick_sum[P_SEL_W-1:0];
  assign w_pick_onehot = {{(P_CROSSBAR_N-1){1'b0}}, 1'b1} << w_pick_idx;

  // Granted line still requesting; grant is one-hot so a masked OR works.
  assign w_req_own  = |(i_trans_req & r_grant);
  // A withdrawal only counts before any beat of the packet has moved,
  // including a beat in this very cycle.
  assign w_withdraw = ~w_req_own & ~r_beat_seen & ~w_beat;

`ifdef CROSSBAR_ARB_TIMEOUT_EN
  localparam int LP_CNT_W = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;
  localparam logic [LP_CNT_W-1:0] LP_CNT_LAST = LP_CNT_W'(P_TIMEOUT - 1);

  logic [LP_CNT_W-1:0] r_stall_cnt;

  assign w_to_hit = (r_state == ST_GRANT) & ~w_beat & (r_stall_cnt == LP_CNT_LAST);

  // Counts consecutive beat-less granted cycles; held at 0 outside GRANT so
  // every new grant starts from zero.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state != ST_GRANT) || w_beat || w_to_hit) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  assign w_release = w_last_beat | w_withdraw | w_to_hit;

  // Next-state and output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_sel_nxt       = r_sel;
    w_rr_nxt        = r_rr_ptr;
    w_beat_seen_nxt = r_beat_seen;
    w_timeout_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_grant_nxt     = w_pick_onehot;
          w_sel_nxt       = w_pick_idx;
          w_beat_seen_nxt = 1'b0;
          w_state_nxt     = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (w_beat) begin
          w_beat_seen_nxt = 1'b1;
        end
        if (w_release) begin
          w_grant_nxt   = '0;
          w_state_nxt   = ST_GAP;
          w_rr_nxt      = (r_sel == LP_LAST) ? '0 : r_sel + 1'b1;
          w_timeout_nxt = w_to_hit;
        end
      end

      ST_GAP: begin
        // One dead cycle before the next arbitration.
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_sel       <= '0;
      r_rr_ptr    <= '0;
      r_beat_seen <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_sel       <= w_sel_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_beat_seen <= w_beat_seen_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign o_trans_grant = r_grant;
  assign o_sel         = r_sel;
  assign o_busy        = |r_grant;
  assign o_timeout     = r_timeout;
  assign o_dbg_state   = r_state;

endmodule
